// File: rtl/multdiv_seq_if.sv
// Request/response bundle between the execute-stage decoder and the mult/div sequencer.
interface multdiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             sig_mult;
  logic             sig_div;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             busy;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             exception;

  // Decoder / pipeline side: issues start requests, observes stall and result.
  modport master (
    output sig_mult, sig_div, data_a, data_b,
    input  busy, result_ready, result, exception
  );

  // Sequencer side.
  modport slave (
    input  sig_mult, sig_div, data_a, data_b,
    output busy, result_ready, result, exception
  );
endinterface

// File: rtl/multdiv_seq.sv
// Iterative signed multiply / restoring divide sequencer. One iteration per
// clock, WIDTH iterations per op; stalls the pipeline via busy while running.
module multdiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  multdiv_seq_if.slave bus
);
  localparam int unsigned W  = WIDTH;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            neg;
  // Multiply datapath: accumulator, left-shifting multiplicand, right-shifting multiplier.
  logic [W2-1:0]   acc;
  logic [W2-1:0]   mcand;
  logic [W-1:0]    mplier;
  // Divide datapath: partial remainder, dividend/quotient shift register, divisor.
  logic [W-1:0]    rem;
  logic [W-1:0]    quot;
  logic [W-1:0]    divisor;
  // Registered outputs.
  logic            busy_q;
  logic            result_ready_q;
  logic [W-1:0]    result_q;
  logic            exception_q;

  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            op_neg;
  logic [W2-1:0]   acc_step;
  logic [W2-1:0]   prod_signed;
  logic            mult_ovf;
  logic [W:0]      div_shift;
  logic            div_fits;
  logic [W-1:0]    rem_step;
  logic [W-1:0]    quot_step;
  logic [W-1:0]    quot_signed;
  logic            div_ovf;
  logic            last_iter;

  // Operand magnitudes and per-iteration step values for both datapaths.
  always_comb begin
    // |MIN| = 2^(W-1) is representable as a W-bit unsigned magnitude.
    mag_a  = bus.data_a[W-1] ? (W'(0) - bus.data_a) : bus.data_a;
    mag_b  = bus.data_b[W-1] ? (W'(0) - bus.data_b) : bus.data_b;
    op_neg = bus.data_a[W-1] ^ bus.data_b[W-1];

    acc_step    = mplier[0] ? (acc + mcand) : acc;
    prod_signed = neg ? (W2'(0) - acc_step) : acc_step;
    // Product fits in W signed bits only if the top W+1 bits are a sign run.
    mult_ovf    = !((&prod_signed[W2-1:W-1]) || (~|prod_signed[W2-1:W-1]));

    div_shift   = {rem, quot[W-1]};
    div_fits    = (div_shift >= {1'b0, divisor});
    rem_step    = div_fits ? W'(div_shift - {1'b0, divisor}) : div_shift[W-1:0];
    quot_step   = {quot[W-2:0], div_fits};
    quot_signed = neg ? (W'(0) - quot_step) : quot_step;
    // Only MIN / -1 yields a positive quotient of 2^(W-1).
    div_ovf     = !neg && quot_step[W-1];

    last_iter   = (cnt == CW'(W - 1));
  end

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      neg            <= 1'b0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      rem            <= '0;
      quot           <= '0;
      divisor        <= '0;
      busy_q         <= 1'b0;
      result_ready_q <= 1'b0;
      result_q       <= '0;
      exception_q    <= 1'b0;
    end else begin
      result_ready_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          if (bus.sig_mult) begin
            state  <= MULT;
            busy_q <= 1'b1;
            cnt    <= '0;
            neg    <= op_neg;
            acc    <= '0;
            mcand  <= W2'(mag_a);
            mplier <= mag_b;
          end else if (bus.sig_div) begin
            if (bus.data_b == '0) begin
              // Divide by zero completes immediately without iterating.
              state          <= DONE;
              result_ready_q <= 1'b1;
              result_q       <= '0;
              exception_q    <= 1'b1;
            end else begin
              state   <= DIV;
              busy_q  <= 1'b1;
              cnt     <= '0;
              neg     <= op_neg;
              rem     <= '0;
              quot    <= mag_a;
              divisor <= mag_b;
            end
          end
        end
        MULT: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            state          <= DONE;
            busy_q         <= 1'b0;
            result_ready_q <= 1'b1;
            result_q       <= prod_signed[W-1:0];
            exception_q    <= mult_ovf;
          end
        end
        DIV: begin
          rem  <= rem_step;
          quot <= quot_step;
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            state          <= DONE;
            busy_q         <= 1'b0;
            result_ready_q <= 1'b1;
            result_q       <= quot_signed;
            exception_q    <= div_ovf;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_ready = result_ready_q;
  assign bus.result       = result_q;
  assign bus.exception    = exception_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed corner cases plus randomized
// ops checked against a plain-arithmetic reference model.
module tb_multdiv_seq;
  localparam int unsigned WIDTH = 32;
  localparam int          LAT   = WIDTH + 1;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  multdiv_seq_if #(.WIDTH(WIDTH)) bus ();

  multdiv_seq #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: exact signed arithmetic in 64 bits.
  function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint pa;
    longint pb;
    longint p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    if (is_mult) begin
      p = pa * pb;
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (pb == 0) begin
      r = '0;
      e = 1'b1;
    end else begin
      p = pa / pb;
      r = p[31:0];
      e = (p > 64'sd2147483647);
    end
  endfunction

  // Issues one op and watches until result_ready (bounded); no checking here.
  task automatic exec_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n, output bit overlap,
                         output logic [31:0] r, output logic e);
    bus.sig_mult = is_mult;
    bus.sig_div  = !is_mult;
    bus.data_a   = a;
    bus.data_b   = b;
    @(posedge clock);
    #1;
    bus.sig_mult = 1'b0;
    bus.sig_div  = 1'b0;
    bus.data_a   = $urandom;
    bus.data_b   = $urandom;
    lat = -1; busy_n = 0; overlap = 1'b0; r = 'x; e = 1'bx;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (bus.busy) busy_n++;
      if (bus.busy && bus.result_ready) overlap = 1'b1;
      if (bus.result_ready) begin
        lat = c;
        r   = bus.result;
        e   = bus.exception;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.sig_mult = 1'b0;
    bus.sig_div  = 1'b0;
    bus.data_a   = '0;
    bus.data_b   = '0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.result_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b ready=%b, required 0 0", bus.busy, bus.result_ready);
    end
    n_tests++;
    if (bus.result !== 32'h0 || bus.exception !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_result: result=%h exc=%b, required 0 0", bus.result, bus.exception);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_tests++;
      if (bus.result_ready !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release: cycle %0d ready=%b busy=%b, required 0 0", c, bus.result_ready, bus.busy);
      end
    end
  endtask

  task automatic test_mult();
    logic [31:0] va [3] = '{32'd6, 32'hFFFF_FFF9, 32'h7FFF_FFFF};
    logic [31:0] vb [3] = '{32'd7, 32'd3, 32'd2};
    logic [31:0] vr [3] = '{32'd42, 32'hFFFF_FFEB, 32'hFFFF_FFFE};
    logic        ve [3] = '{1'b0, 1'b0, 1'b1};
    int lat, busy_n; bit ov; logic [31:0] r; logic e;
    for (int i = 0; i < 3; i++) begin
      exec_op(1'b1, va[i], vb[i], lat, busy_n, ov, r, e);
      n_tests++;
      if (lat !== LAT || busy_n !== WIDTH || ov) begin
        n_fail++;
        $display("FAIL mult_timing[%0d]: lat=%0d busy=%0d overlap=%b, required %0d %0d 0", i, lat, busy_n, ov, LAT, WIDTH);
      end
      n_tests++;
      if (r !== vr[i] || e !== ve[i]) begin
        n_fail++;
        $display("FAIL mult_value[%0d]: result=%h exc=%b, required %h %b", i, r, e, vr[i], ve[i]);
      end
      @(negedge clock);
      n_tests++;
      if (bus.result_ready !== 1'b0 || bus.result !== vr[i] || bus.exception !== ve[i]) begin
        n_fail++;
        $display("FAIL mult_hold[%0d]: ready=%b result=%h exc=%b, required 0 %h %b", i, bus.result_ready, bus.result, bus.exception, vr[i], ve[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] va [4] = '{32'd100, 32'hFFFF_FF9C, 32'h8000_0000, 32'd5};
    logic [31:0] vb [4] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] vr [4] = '{32'd14, 32'hFFFF_FFF2, 32'h8000_0000, 32'd0};
    logic        ve [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          vl [4] = '{LAT, LAT, LAT, 1};
    int lat, busy_n; bit ov; logic [31:0] r; logic e;
    for (int i = 0; i < 4; i++) begin
      exec_op(1'b0, va[i], vb[i], lat, busy_n, ov, r, e);
      n_tests++;
      if (lat !== vl[i] || busy_n !== vl[i] - 1 || ov) begin
        n_fail++;
        $display("FAIL div_timing[%0d]: lat=%0d busy=%0d overlap=%b, required %0d %0d 0", i, lat, busy_n, ov, vl[i], vl[i] - 1);
      end
      n_tests++;
      if (r !== vr[i] || e !== ve[i]) begin
        n_fail++;
        $display("FAIL div_value[%0d]: result=%h exc=%b, required %h %b", i, r, e, vr[i], ve[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_ignore();
    int lat = -1;
    int readies = 0;
    logic [31:0] r = 'x;
    bus.sig_mult = 1'b1; bus.data_a = 32'd6; bus.data_b = 32'd7;
    @(posedge clock);
    #1;
    bus.sig_mult = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      if (c == 10) begin
        bus.sig_div = 1'b1; bus.data_a = 32'd9; bus.data_b = 32'd3;
      end else begin
        bus.sig_div = 1'b0;
      end
      if (bus.result_ready) begin
        readies++;
        if (lat < 0) begin
          lat = c;
          r   = bus.result;
        end
      end
    end
    n_tests++;
    if (lat !== LAT || r !== 32'd42 || readies !== 1) begin
      n_fail++;
      $display("FAIL ignore_start: lat=%0d result=%h readies=%0d, required %0d 0000002a 1", lat, r, readies, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n; bit ov; logic [31:0] r; logic e;
    exec_op(1'b0, 32'd100, 32'd7, lat, busy_n, ov, r, e);
    n_tests++;
    if (lat !== LAT || r !== 32'd14) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d result=%h, required %0d 0000000e", lat, r, LAT);
    end
    // Started from the DONE cycle of the previous op.
    bus.sig_mult = 1'b1; bus.data_a = 32'hFFFF_FFF9; bus.data_b = 32'd3;
    @(posedge clock);
    #1;
    bus.sig_mult = 1'b0;
    @(negedge clock);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.result_ready !== 1'b0 || bus.result !== 32'd14) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b ready=%b result=%h, required 1 0 0000000e", bus.busy, bus.result_ready, bus.result);
    end
    lat = -1;
    for (int c = 2; c <= 100; c++) begin
      @(negedge clock);
      if (bus.result_ready) begin
        lat = c;
        break;
      end
    end
    n_tests++;
    if (lat !== LAT || bus.result !== 32'hFFFF_FFEB || bus.exception !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d result=%h exc=%b, required %0d ffffffeb 0", lat, bus.result, bus.exception, LAT);
    end
    exec_op(1'b0, 32'd5, 32'd0, lat, busy_n, ov, r, e);
    exec_op(1'b1, 32'd2, 32'd3, lat, busy_n, ov, r, e);
    n_tests++;
    if (lat !== LAT || r !== 32'd6 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_after_div0: lat=%0d result=%h exc=%b, required %0d 00000006 0", lat, r, e, LAT);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int lat, busy_n; bit ov; logic [31:0] r; logic e;
    int seen = 0;
    exec_op(1'b1, 32'h7FFF_FFFF, 32'd2, lat, busy_n, ov, r, e);
    @(negedge clock);
    bus.sig_mult = 1'b1; bus.data_a = 32'd6; bus.data_b = 32'd7;
    @(posedge clock);
    #1;
    bus.sig_mult = 1'b0;
    repeat (15) @(negedge clock);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.result !== 32'hFFFF_FFFE || bus.exception !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: busy=%b result=%h exc=%b, required 1 fffffffe 1", bus.busy, bus.result, bus.exception);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.result !== 32'h0 || bus.exception !== 1'b0 || bus.result_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: busy=%b result=%h exc=%b ready=%b, required 0 0 0 0", bus.busy, bus.result, bus.exception, bus.result_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (bus.result_ready || bus.busy) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d active cycles after reset, required 0", seen);
    end
    exec_op(1'b1, 32'd2, 32'd3, lat, busy_n, ov, r, e);
    n_tests++;
    if (lat !== LAT || r !== 32'd6 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_next: lat=%0d result=%h exc=%b, required %0d 00000006 0", lat, r, e, LAT);
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] special [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h1, 32'hFFFF_FFFE};
    int sel = $urandom_range(0, 7);
    if (sel == 0) return special[$urandom_range(0, 5)];
    if (sel <= 2) return 32'($signed($urandom_range(0, 2000)) - 1000);
    if (sel == 3) return 32'($urandom_range(0, 32'h0001_FFFF));
    return 32'($urandom);
  endfunction

  task automatic test_random();
    int lat, busy_n, exp_lat; bit ov; logic [31:0] r, a, b, er; logic e, ee; bit is_mult;
    for (int i = 0; i < 200; i++) begin
      is_mult = $urandom_range(0, 1) == 1;
      a = pick_operand();
      b = pick_operand();
      model(is_mult, a, b, er, ee);
      exp_lat = (!is_mult && b == 32'h0) ? 1 : LAT;
      exec_op(is_mult, a, b, lat, busy_n, ov, r, e);
      n_tests++;
      if (lat !== exp_lat || busy_n !== exp_lat - 1 || ov || r !== er || e !== ee) begin
        n_fail++;
        $display("FAIL random[%0d] %s %h,%h: result=%h exc=%b lat=%0d busy=%0d ov=%b, required %h %b %0d %0d 0",
                 i, is_mult ? "mult" : "div", a, b, r, e, lat, busy_n, ov, er, ee, exp_lat, exp_lat - 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_mult();
    test_div();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
